// File: rtl/mac_array_ctrl_if.sv
// rtl/mac_array_ctrl_if.sv - B FIFO, MAC array and result-port signals of the MAC sequencer
// master: the sequencer side; slave: the FIFO/array/consumer side.
interface mac_array_ctrl_if #(
    parameter int ROWS = 8
);
    logic        b_empty;
    logic        b_pop;
    logic        mac_clr;
    logic        mac_en;
    logic [23:0] mac_c_in [0:ROWS-1];
    logic        res_valid;
    logic        res_ready;
    logic [23:0] res_data [0:ROWS-1];

    modport master (
        input  b_empty,
        input  mac_c_in,
        input  res_ready,
        output b_pop,
        output mac_clr,
        output mac_en,
        output res_valid,
        output res_data
    );

    modport slave (
        output b_empty,
        output mac_c_in,
        output res_ready,
        input  b_pop,
        input  mac_clr,
        input  mac_en,
        input  res_valid,
        input  res_data
    );
endinterface

// File: rtl/mac_array_ctrl.sv
// rtl/mac_array_ctrl.sv - job sequencer for the systolic MAC array (clear, feed B, drain, hold result)
// Optional stall_cycles performance counter is built when MAC_CTRL_PERF_EN is defined.
module mac_array_ctrl #(
    parameter int ROWS         = 8,
    parameter int VEC_LEN      = 8,
    parameter int DRAIN_CYCLES = ROWS + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
`ifdef MAC_CTRL_PERF_EN
    output logic [15:0] stall_cycles,
`endif
    mac_array_ctrl_if.master bus
);

    localparam int FCW = $clog2(VEC_LEN + 1);
    localparam int DCW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [FCW-1:0] FEED_LAST  = FCW'(VEC_LEN - 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [FCW-1:0]   feed_cnt_q, feed_cnt_d;
    logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [23:0]      res_data_q [0:ROWS-1];
    logic [23:0]      res_data_d [0:ROWS-1];
    logic             done_q, done_d;
    logic             mac_clr_c;
    logic             mac_en_c;
    logic             res_valid_c;
`ifdef MAC_CTRL_PERF_EN
    logic [15:0]      stall_q, stall_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            feed_cnt_q  <= '0;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                res_data_q[r] <= '0;
            end
`ifdef MAC_CTRL_PERF_EN
            stall_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            feed_cnt_q  <= feed_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
            for (int r = 0; r < ROWS; r++) begin
                res_data_q[r] <= res_data_d[r];
            end
`ifdef MAC_CTRL_PERF_EN
            stall_q     <= stall_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        feed_cnt_d  = feed_cnt_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        mac_clr_c   = 1'b0;
        mac_en_c    = 1'b0;
        res_valid_c = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            res_data_d[r] = res_data_q[r];
        end
`ifdef MAC_CTRL_PERF_EN
        stall_d     = stall_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end

            S_CLEAR: begin
                mac_clr_c   = 1'b1;
                feed_cnt_d  = '0;
                drain_cnt_d = '0;
                state_d     = S_FEED;
`ifdef MAC_CTRL_PERF_EN
                stall_d     = '0;
`endif
            end

            S_FEED: begin
                // Enable and pop share one strobe: the show-ahead head is consumed by row 0 this cycle.
                if (!bus.b_empty) begin
                    mac_en_c   = 1'b1;
                    feed_cnt_d = feed_cnt_q + FCW'(1);
                    if (feed_cnt_q == FEED_LAST) begin
                        state_d = S_DRAIN;
                    end
                end
`ifdef MAC_CTRL_PERF_EN
                else if (stall_q != 16'hFFFF) begin
                    stall_d = stall_q + 16'd1;
                end
`endif
            end

            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q + DCW'(1);
                if (drain_cnt_q == DRAIN_LAST) begin
                    for (int r = 0; r < ROWS; r++) begin
                        res_data_d[r] = bus.mac_c_in[r];
                    end
                    state_d = S_HOLD;
                end
            end

            S_HOLD: begin
                res_valid_c = 1'b1;
                if (bus.res_ready) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign bus.mac_clr   = mac_clr_c;
    assign bus.mac_en    = mac_en_c;
    assign bus.b_pop     = mac_en_c;
    assign bus.res_valid = res_valid_c;
    assign bus.res_data  = res_data_q;
`ifdef MAC_CTRL_PERF_EN
    assign stall_cycles  = stall_q;
`endif

endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb/tb_mac_array_ctrl.sv - directed self-checking bench for mac_array_ctrl with a behavioural FIFO and systolic array
// Build with MAC_CTRL_PERF_EN defined to also cover the stall counter.
module tb_mac_array_ctrl;

    localparam int ROWS = 8;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic done;
`ifdef MAC_CTRL_PERF_EN
    logic [15:0] stall_cycles;
`endif

    mac_array_ctrl_if #(.ROWS(ROWS)) ifc ();

    mac_array_ctrl #(.ROWS(ROWS), .VEC_LEN(8), .DRAIN_CYCLES(ROWS + 1)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
`ifdef MAC_CTRL_PERF_EN
        .stall_cycles (stall_cycles),
`endif
        .bus          (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // B FIFO model: show-ahead, flushed by reset
    logic [7:0] bmem [0:255];
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr;
    logic       stall_force;
    assign ifc.b_empty = (rd_ptr == wr_ptr) || stall_force;

    always @(posedge clk) begin
        if (rst) rd_ptr <= wr_ptr;
        else if (ifc.b_pop) rd_ptr <= rd_ptr + 8'd1;
    end

    // Systolic array model: row r sees enable/B r+1 edges after row-0 feed; A(r,k) = 3r+k+1
    logic [23:0] acc  [0:ROWS-1];
    logic [7:0]  bp   [0:ROWS-1];
    logic [ROWS-1:0] en_p;
    int          kidx [0:ROWS-1];

    always @(posedge clk) begin
        if (rst) begin
            en_p <= '0;
            for (int r = 0; r < ROWS; r++) begin
                acc[r]  <= '0;
                bp[r]   <= '0;
                kidx[r] <= 0;
            end
        end else begin
            en_p  <= {en_p[ROWS-2:0], ifc.mac_en};
            bp[0] <= bmem[rd_ptr];
            for (int r = 1; r < ROWS; r++) bp[r] <= bp[r-1];
            if (ifc.mac_clr) begin
                for (int r = 0; r < ROWS; r++) begin
                    acc[r]  <= '0;
                    kidx[r] <= 0;
                end
            end else begin
                for (int r = 0; r < ROWS; r++) begin
                    if (en_p[r]) begin
                        acc[r]  <= acc[r] + 24'((3 * r + kidx[r] + 1) * int'(bp[r]));
                        kidx[r] <= kidx[r] + 1;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < ROWS; r++) ifc.mac_c_in[r] = acc[r];
    end

    // Event monitors; tasks work on deltas of these counters
    int en_cnt = 0, pop_cnt = 0, clr_cnt = 0, done_cnt = 0, overlap_cnt = 0;
    int en_run = 0, last_run = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (ifc.mac_en) en_cnt <= en_cnt + 1;
            if (ifc.b_pop) pop_cnt <= pop_cnt + 1;
            if (ifc.mac_clr) clr_cnt <= clr_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (ifc.mac_clr && ifc.mac_en) overlap_cnt <= overlap_cnt + 1;
            if (ifc.mac_en) en_run <= en_run + 1;
            else begin
                if (en_run != 0) last_run <= en_run;
                en_run <= 0;
            end
        end
    end

    function automatic logic [23:0] exp_row(int r, logic [7:0] base);
        logic [31:0] s;
        logic [7:0]  idx;
        s = 0;
        for (int k = 0; k < 8; k++) begin
            idx = base + 8'(k);
            s = s + 32'((3 * r + k + 1) * int'(bmem[idx]));
        end
        return s[23:0];
    endfunction

    task automatic push_job(input int seed);
        for (int k = 0; k < 8; k++) begin
            bmem[wr_ptr] = 8'(seed * 17 + k * 29 + 3);
            wr_ptr = wr_ptr + 8'd1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns edges waited until res_valid, or -1 when the budget runs out
    task automatic wait_valid(output int n);
        n = 0;
        while (!ifc.res_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ifc.res_valid) n = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if ({ifc.mac_clr, ifc.mac_en, ifc.b_pop, ifc.res_valid} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes got=%b exp=0000", {ifc.mac_clr, ifc.mac_en, ifc.b_pop, ifc.res_valid});
        end
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (ifc.res_data[r] !== 24'd0) begin errors++; $display("FAIL reset_res_data[%0d] got=%h exp=0", r, ifc.res_data[r]); end
        end
`ifdef MAC_CTRL_PERF_EN
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles); end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_job();
        logic [7:0] base;
        int n, c0, e0, p0, o0;
        base = wr_ptr;
        push_job(1);
        c0 = clr_cnt; e0 = en_cnt; p0 = pop_cnt; o0 = overlap_cnt;
        pulse_start();
        wait_valid(n);
        checks++; if (n + 1 !== 19) begin errors++; $display("FAIL single_latency got=%0d exp=19", n + 1); end
        checks++; if (clr_cnt - c0 !== 1) begin errors++; $display("FAIL single_clr_cycles got=%0d exp=1", clr_cnt - c0); end
        checks++; if (en_cnt - e0 !== 8) begin errors++; $display("FAIL single_en_cycles got=%0d exp=8", en_cnt - e0); end
        checks++; if (pop_cnt - p0 !== 8) begin errors++; $display("FAIL single_pops got=%0d exp=8", pop_cnt - p0); end
        checks++; if (last_run !== 8) begin errors++; $display("FAIL single_en_run got=%0d exp=8", last_run); end
        checks++; if (overlap_cnt - o0 !== 0) begin errors++; $display("FAIL single_clr_en_overlap got=%0d exp=0", overlap_cnt - o0); end
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (ifc.res_data[r] !== exp_row(r, base)) begin
                errors++; $display("FAIL single_res_data[%0d] got=%h exp=%h", r, ifc.res_data[r], exp_row(r, base));
            end
        end
        ifc.res_ready = 1'b1;
        @(posedge clk); #1;
        ifc.res_ready = 1'b0;
        checks++; if (done !== 1'b1 || ifc.res_valid !== 1'b0) begin
            errors++; $display("FAIL single_done got done=%b valid=%b exp done=1 valid=0", done, ifc.res_valid);
        end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_after_done got done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    task automatic test_stalls();
        logic [7:0] base;
        int cyc, st, p0;
        bit stalled;
        base = wr_ptr;
        push_job(2);
        p0 = pop_cnt;
        stalled = 0; st = 0;
        pulse_start();
        cyc = 1;
        while (!ifc.res_valid && cyc < 200) begin
            if (pop_cnt - p0 == 4 && !stalled) begin
                stall_force = 1'b1; stalled = 1; st = cyc;
            end else if (stall_force && cyc == st + 3) begin
                stall_force = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        stall_force = 1'b0;
        checks++; if (cyc !== 22) begin errors++; $display("FAIL stall_latency got=%0d exp=22", cyc); end
        checks++; if (pop_cnt - p0 !== 8) begin errors++; $display("FAIL stall_pops got=%0d exp=8", pop_cnt - p0); end
        for (int r = 0; r < ROWS; r += 3) begin
            checks++; if (ifc.res_data[r] !== exp_row(r, base)) begin
                errors++; $display("FAIL stall_res_data[%0d] got=%h exp=%h", r, ifc.res_data[r], exp_row(r, base));
            end
        end
`ifdef MAC_CTRL_PERF_EN
        checks++; if (stall_cycles !== 16'd3) begin errors++; $display("FAIL stall_count got=%0d exp=3", stall_cycles); end
`endif
        ifc.res_ready = 1'b1;
        @(posedge clk); #1;
        ifc.res_ready = 1'b0;
        @(posedge clk); #1;
`ifdef MAC_CTRL_PERF_EN
        checks++; if (stall_cycles !== 16'd3) begin errors++; $display("FAIL stall_count_idle got=%0d exp=3", stall_cycles); end
`endif
    endtask

    task automatic test_backpressure();
        logic [7:0] base;
        int n, d0, bad;
        base = wr_ptr;
        push_job(3);
        d0 = done_cnt;
        pulse_start();
        wait_valid(n);
        checks++; if (n < 0) begin errors++; $display("FAIL bp_timeout got=timeout exp=res_valid"); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (ifc.res_valid !== 1'b1) bad++;
            for (int r = 0; r < ROWS; r++) if (ifc.res_data[r] !== exp_row(r, base)) bad++;
            @(posedge clk); #1;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got=%0d_bad_samples exp=0", bad); end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL bp_early_done got=%0d exp=0", done_cnt - d0); end
        ifc.res_ready = 1'b1;
        @(posedge clk); #1;
        ifc.res_ready = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got=%b exp=1", done); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_start_in_flight();
        logic [7:0] base;
        int n, c0, d0, drops;
        base = wr_ptr;
        push_job(4);
        c0 = clr_cnt; d0 = done_cnt;
        drops = 0; n = 0;
        start = 1'b1;
        @(posedge clk); #1;
        while (!ifc.res_valid && n < 200) begin
            if (busy !== 1'b1) drops++;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        checks++; if (drops !== 0 || n >= 200) begin errors++; $display("FAIL sif_busy got=%0d_drops exp=0", drops); end
        checks++; if (ifc.res_data[7] !== exp_row(7, base)) begin
            errors++; $display("FAIL sif_res_data got=%h exp=%h", ifc.res_data[7], exp_row(7, base));
        end
        ifc.res_ready = 1'b1;
        @(posedge clk); #1;
        ifc.res_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sif_idle got=%b exp=0", busy); end
        checks++; if (clr_cnt - c0 !== 1 || done_cnt - d0 !== 1) begin
            errors++; $display("FAIL sif_jobs got clr=%0d done=%0d exp 1 1", clr_cnt - c0, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_feed();
        logic [7:0] base;
        int n, p0, d0, bad;
        push_job(5);
        p0 = pop_cnt; d0 = done_cnt;
        pulse_start();
        n = 0;
        while (pop_cnt - p0 < 4 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (pop_cnt - p0 !== 4) begin errors++; $display("FAIL rmf_pops got=%0d exp=4", pop_cnt - p0); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if ({busy, done, ifc.mac_clr, ifc.mac_en, ifc.b_pop, ifc.res_valid} !== 6'b0) begin
            errors++; $display("FAIL rmf_outputs got=%b exp=000000", {busy, done, ifc.mac_clr, ifc.mac_en, ifc.b_pop, ifc.res_valid});
        end
        bad = 0;
        for (int r = 0; r < ROWS; r++) if (ifc.res_data[r] !== 24'd0) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL rmf_res_data got=%0d_nonzero exp=0", bad); end
        @(posedge clk); #1;
        base = wr_ptr;
        push_job(6);
        pulse_start();
        wait_valid(n);
        checks++; if (n + 1 !== 19) begin errors++; $display("FAIL rmf_latency got=%0d exp=19", n + 1); end
        for (int r = 0; r < ROWS; r += 2) begin
            checks++; if (ifc.res_data[r] !== exp_row(r, base)) begin
                errors++; $display("FAIL rmf_res_data[%0d] got=%h exp=%h", r, ifc.res_data[r], exp_row(r, base));
            end
        end
        ifc.res_ready = 1'b1;
        @(posedge clk); #1;
        ifc.res_ready = 1'b0;
        checks++; if (done_cnt - d0 !== 0 || done !== 1'b1) begin
            errors++; $display("FAIL rmf_done got prior=%0d now=%b exp 0 1", done_cnt - d0, done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] base1, base2;
        int n;
        base1 = wr_ptr;
        push_job(7);
        base2 = wr_ptr;
        push_job(8);
        pulse_start();
        wait_valid(n);
        for (int r = 0; r < ROWS; r += 4) begin
            checks++; if (ifc.res_data[r] !== exp_row(r, base1)) begin
                errors++; $display("FAIL b2b_job1[%0d] got=%h exp=%h", r, ifc.res_data[r], exp_row(r, base1));
            end
        end
        ifc.res_ready = 1'b1;
        @(posedge clk); #1;
        ifc.res_ready = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b exp=1", done); end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1 || ifc.mac_clr !== 1'b1) begin
            errors++; $display("FAIL b2b_clear got busy=%b clr=%b exp 1 1", busy, ifc.mac_clr);
        end
        wait_valid(n);
        checks++; if (n + 1 !== 19) begin errors++; $display("FAIL b2b_latency got=%0d exp=19", n + 1); end
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (ifc.res_data[r] !== exp_row(r, base2)) begin
                errors++; $display("FAIL b2b_job2[%0d] got=%h exp=%h", r, ifc.res_data[r], exp_row(r, base2));
            end
        end
        ifc.res_ready = 1'b1;
        @(posedge clk); #1;
        ifc.res_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        wr_ptr        = 8'd0;
        stall_force   = 1'b0;
        start         = 1'b0;
        rst           = 1'b1;
        ifc.res_ready = 1'b0;
        for (int i = 0; i < 256; i++) bmem[i] = 8'd0;
        test_reset();
        test_single_job();
        test_stalls();
        test_backpressure();
        test_start_in_flight();
        test_reset_mid_feed();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_array_ctrl.md
# mac_array_ctrl

Sequencer for the 8-row systolic MAC array. On a `start` pulse it clears the accumulators and streams `VEC_LEN` B operands from a show-ahead B FIFO into the array, stalling whenever that FIFO is empty. It then waits for the enable/B wavefront to drain through all rows, captures the eight 24-bit accumulators, and presents them on a valid/ready result port. The block sits between the top-level command logic and `mac_array`; A-FIFO pops remain driven by the array's exported per-row enables.

## Interface
- `ROWS`, 8: number of MAC rows; must match the array.
- `VEC_LEN`, 8: B operands per job, ≥1.
- `DRAIN_CYCLES`, `ROWS+1`: cycles from the last enabled feed to a stable final accumulator in row `ROWS-1`.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: job request; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the result is accepted.
- `b_empty` in 1: B FIFO empty flag.
- `b_pop` out 1: B FIFO read strobe; the head data is consumed in the same cycle.
- `mac_clr` out 1: accumulator clear to the array.
- `mac_en` out 1: enable into row 0 of the array.
- `mac_c_in` in `[0:ROWS-1]` × 24: accumulator outputs from the array.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out `[0:ROWS-1]` × 24: captured results.
- `stall_cycles` out 16: present only with `MAC_CTRL_PERF_EN` (see Configuration).

## Operation
- **States:** IDLE, CLEAR, FEED, DRAIN, HOLD.
- **IDLE:** if `start`=1, go to CLEAR. Otherwise stay in IDLE.
- **CLEAR:** `mac_clr`=1 for exactly one cycle. Reset `feed_cnt` and `drain_cnt` to 0. Go to FEED.
- **FEED:** `mac_en` = `b_pop` = `!b_empty`. This is combinational from state and `b_empty`.
  - On each feed, `feed_cnt` increments.
  - When a feed occurs with `feed_cnt`==`VEC_LEN-1`, go to DRAIN.
  - When `b_empty`=1, the cycle is a stall: no enable, no pop, no count.
- **DRAIN:** `mac_en`=0 and `b_pop`=0. `drain_cnt` increments every cycle.
  - When `drain_cnt`==`DRAIN_CYCLES-1`, load `res_data` ← `mac_c_in` and go to HOLD.
- **HOLD:** `res_valid`=1 and `res_data` is stable.
  - When `res_valid`&&`res_ready`, go to IDLE. `done` is registered and pulses high in the following cycle.
- **Start handling:** `start` outside IDLE is ignored and not queued.
- **Counters:** `feed_cnt` is `$clog2(VEC_LEN+1)` bits. `drain_cnt` is `$clog2(DRAIN_CYCLES+1)` bits. Neither counter wraps, because both exit at their terminal value.
- **Arithmetic:** the controller does no data arithmetic. Accumulator width and any overflow are owned by the array; `res_data` is a straight capture.

## Timing
- **Reset values:** all outputs 0. This includes `res_data` (all rows), `stall_cycles`, `done`, `busy`, `mac_clr`, `mac_en`, `b_pop` and `res_valid`. State is IDLE and both counters are 0.
- **Reset mid-job:** any state returns to IDLE on the next edge. No `done` pulse is produced, and popped B data is lost.
- **Job timeline:** `start` high at edge t gives CLEAR during cycle t+1 and FEED from t+2.
- **Minimum latency:** with no stalls, `start` to `res_valid` is 1 + `VEC_LEN` + `DRAIN_CYCLES` + 1 cycles. The default parameters give 19.
- **Stalls:** each stall cycle in FEED adds exactly one cycle to that latency.
- **CLEAR vs. enable:** `mac_clr` and `mac_en` are never high in the same cycle.
- **Back-to-back jobs:** `start` asserted in the same cycle as the `done` pulse is accepted, because the state is IDLE. `busy` rises on the next edge.
- **Result hold:** `res_ready` held low keeps HOLD, `res_valid` and `res_data` indefinitely.
- **Same-cycle acceptance:** `res_ready` high when HOLD is entered accepts in the first HOLD cycle.

## Configuration
- **`MAC_CTRL_PERF_EN` defined:**
  - `stall_cycles` port exists.
  - It counts FEED cycles with `b_empty`=1.
  - It clears in CLEAR and saturates at 16'hFFFF.
  - It holds its value through DRAIN, HOLD and IDLE.
- **Not defined:** the port and counter are absent. Behaviour is otherwise identical.

## Test plan
- **Single job, no stalls:** B FIFO preloaded with 8 entries, `start` pulse.
  - `mac_clr` high 1 cycle.
  - `mac_en`/`b_pop` high 8 consecutive cycles.
  - `res_valid` 19 cycles after `start`.
  - `res_data` equals the reference dot products.
- **Stalls:** `b_empty`=1 for 3 cycles mid-FEED.
  - Exactly 8 pops.
  - `res_valid` at cycle 22.
  - `stall_cycles`=3 with the macro defined.
- **Backpressure:** `res_ready`=0 for 10 cycles in HOLD.
  - `res_data` is unchanged over the hold.
  - `done` pulses exactly once, one cycle after `res_ready` rises.
- **Start in flight:** `start` re-asserted during FEED and DRAIN.
  - Ignored.
  - Only one job completes and `busy` stays continuous.
- **Reset mid-FEED:** `rst` asserted after 4 pops.
  - Next cycle all outputs are 0 and state is IDLE.
  - A new job then completes normally with freshly cleared accumulators.
- **Back-to-back:** `start` asserted in the `done` cycle.
  - Second job's CLEAR occurs in the following cycle.
  - Both results are correct.
